ad_envelope_gen: RTL and testbench

//  One-shot Attack/Decay envelope generator for the synth voice path.
//  A rising edge on note_pressed starts a linear ramp from the current level up to a peak set by amplitude,

---
 rtl/ad_envelope_gen.sv | 159 +++++++++++++++
 tb/tb_ad_envelope_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_envelope_gen.sv
// ---------------------------------------------------------------------------
// ad_envelope_gen
//
// One-shot Attack/Decay envelope generator for the synth voice path.
// A rising edge on note_pressed starts a linear ramp from the current level
// up to the peak P = {amplitude, 1'b0}, followed by a linear ramp down to 0.
// Note release is ignored. Time advances only on sample_tick.
//
// Ports
//   clk           in   1        system clock, rising edge
//   rst           in   1        asynchronous reset, active low
//   sample_tick   in   1        1-clk sample strobe from the clock divider
//   attack_time   in   TIME_W   sample ticks per +1 step (0 = jump to peak)
//   decay_time    in   TIME_W   sample ticks per -1 step (0 = jump to 0)
//   amplitude     in   AMP_W    peak level, P = {amplitude, 1'b0}
//   note_pressed  in   1        note gate, synchronous to clk
//   envelope      out  ENV_W    current envelope level, registered
//
// ENV_W is expected to equal AMP_W + 1 so that the peak fits exactly.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module ad_envelope_gen #(
    parameter int TIME_W = 16,
    parameter int AMP_W  = 7,
    parameter int ENV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic [TIME_W-1:0] attack_time,
    input  logic [TIME_W-1:0] decay_time,
    input  logic [AMP_W-1:0]  amplitude,
    input  logic              note_pressed,
    output logic [ENV_W-1:0]  envelope
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ATTACK = 2'd1,
        ST_DECAY  = 2'd2
    } state_t;

    state_t              state;
    logic                note_prev;   // note_pressed from the previous clk
    logic                armed;       // note has been seen low since reset
    logic [ENV_W-1:0]    peak;        // latched P
    logic [TIME_W-1:0]   atk_time;    // latched A
    logic [TIME_W-1:0]   dec_time;    // latched D
    logic [TIME_W-1:0]   cnt;         // ticks since the last level step

    logic                trigger;
    logic [ENV_W-1:0]    peak_next;
    logic [TIME_W:0]     cnt_inc;     // one bit wider so cnt+1 cannot wrap
    logic                atk_step;
    logic                dec_step;
    logic [ENV_W-1:0]    env_inc;
    logic [ENV_W-1:0]    env_dec;

    // A note held high through reset must not start a ramp when reset is
    // released: the edge detector only fires once the gate has been low at
    // least once since reset.
    assign trigger   = note_pressed & ~note_prev & armed;
    assign peak_next = {amplitude, 1'b0};
    assign cnt_inc   = {1'b0, cnt} + (TIME_W+1)'(1);
    assign atk_step  = (atk_time == '0) || (cnt_inc >= {1'b0, atk_time});
    assign dec_step  = (dec_time == '0) || (cnt_inc >= {1'b0, dec_time});
    assign env_inc   = envelope + ENV_W'(1);
    assign env_dec   = envelope - ENV_W'(1);

    // NOTE: every register here is state, so all assignments are
    // non-blocking; blocking writes would let later statements see
    // half-updated values and create simulation/synthesis mismatches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            envelope  <= '0;
            cnt       <= '0;
            note_prev <= 1'b0;
            armed     <= 1'b0;
            peak      <= '0;
            atk_time  <= '0;
            dec_time  <= '0;
        end else begin
            note_prev <= note_pressed;
            if (!note_pressed) begin
                armed <= 1'b1;
            end

            if (trigger) begin
                // Retrigger restarts from the current level; a tick landing
                // in this same cycle is deliberately dropped.
                peak     <= peak_next;
                atk_time <= attack_time;
                dec_time <= decay_time;
                cnt      <= '0;
                if ((peak_next == '0) && (envelope == '0)) begin
                    state <= ST_IDLE;
                end else if (envelope < peak_next) begin
                    state <= ST_ATTACK;
                end else begin
                    state <= ST_DECAY;
                end
            end else if (sample_tick) begin
                case (state)
                    ST_IDLE: begin
                        envelope <= '0;
                        cnt      <= '0;
                    end

                    ST_ATTACK: begin
                        if (atk_time == '0) begin
                            envelope <= peak;
                            cnt      <= '0;
                            state    <= ST_DECAY;
                        end else if (envelope >= peak) begin
                            // Cannot be entered with envelope >= peak; kept so
                            // the level can never overshoot the latched peak.
                            envelope <= peak;
                            cnt      <= '0;
                            state    <= ST_DECAY;
                        end else if (atk_step) begin
                            envelope <= env_inc;
                            cnt      <= '0;
                            if (env_inc == peak) begin
                                state <= ST_DECAY;
                            end
                        end else begin
                            cnt <= cnt_inc[TIME_W-1:0];
                        end
                    end

                    ST_DECAY: begin
                        if ((dec_time == '0) || (envelope == '0)) begin
                            envelope <= '0;
                            cnt      <= '0;
                            state    <= ST_IDLE;
                        end else if (dec_step) begin
                            envelope <= env_dec;
                            cnt      <= '0;
                            if (env_dec == '0) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt_inc[TIME_W-1:0];
                        end
                    end

                    default: begin
                        envelope <= '0;
                        cnt      <= '0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad_envelope_gen.sv
// ---------------------------------------------------------------------------
// tb_ad_envelope_gen
//
// Directed bench for ad_envelope_gen. A behavioural model describes the
// envelope as a closed-form function of (start level, peak, A, D, ticks since
// the trigger); a compare process checks the DUT against it every clk, and
// literal checks pin the hand-computed landmarks of each scenario.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_ad_envelope_gen;

    localparam int TIME_W = 16;
    localparam int AMP_W  = 7;
    localparam int ENV_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sample_tick = 1'b0;
    logic [TIME_W-1:0] attack_time = '0;
    logic [TIME_W-1:0] decay_time = '0;
    logic [AMP_W-1:0]  amplitude = '0;
    logic              note_pressed = 1'b0;
    logic [ENV_W-1:0]  envelope;

    int n_compared   = 0;
    int n_mismatched = 0;
    int tick_period  = 10;

    ad_envelope_gen #(
        .TIME_W (TIME_W),
        .AMP_W  (AMP_W),
        .ENV_W  (ENV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .attack_time  (attack_time),
        .decay_time   (decay_time),
        .amplitude    (amplitude),
        .note_pressed (note_pressed),
        .envelope     (envelope)
    );

    always #10 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: the level is a function of the tick count k since
    // the last trigger. Attack climbs one step per A ticks until the peak,
    // decay then falls one step per D ticks until 0.
    // ------------------------------------------------------------------
    int m_start, m_peak, m_a, m_d, m_k;
    bit m_prev, m_armed;

    function automatic int model_env();
        int t_a, kd, lvl, v;
        if (m_start < m_peak) begin
            t_a = (m_a == 0) ? 1 : (m_peak - m_start) * m_a;
            if (m_k < t_a) begin
                return (m_a == 0) ? m_start : m_start + m_k / m_a;
            end
            kd  = m_k - t_a;
            lvl = m_peak;
        end else begin
            kd  = m_k;
            lvl = m_start;
        end
        if (m_d == 0) begin
            return (kd >= 1) ? 0 : lvl;
        end
        v = lvl - kd / m_d;
        return (v > 0) ? v : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_start <= 0;
            m_peak  <= 0;
            m_a     <= 0;
            m_d     <= 0;
            m_k     <= 0;
            m_prev  <= 1'b0;
            m_armed <= 1'b0;
        end else begin
            m_prev <= note_pressed;
            if (!note_pressed) begin
                m_armed <= 1'b1;
            end
            if (note_pressed && !m_prev && m_armed) begin
                m_start <= model_env();
                m_peak  <= 2 * int'(amplitude);
                m_a     <= int'(attack_time);
                m_d     <= int'(decay_time);
                m_k     <= 0;
            end else if (sample_tick) begin
                m_k <= m_k + 1;
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        n_compared++;
        if (int'(envelope) != model_env()) begin
            n_mismatched++;
            if (n_mismatched <= 20) begin
                $display("FAIL model_cmp t=%0t envelope=%0d expected=%0d",
                         $time, envelope, model_env());
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue n sample ticks, one every tick_period clks; returns on the
    // negedge right after the clk that consumed the last tick.
    task automatic run_ticks(input int n);
        repeat (n) begin
            repeat (tick_period - 1) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    endtask

    task automatic pulse_note();
        note_pressed = 1'b1;
        idle(1);
        note_pressed = 1'b0;
    endtask

    task automatic set_voice(input int a, input int d, input int amp);
        attack_time = TIME_W'(a);
        decay_time  = TIME_W'(d);
        amplitude   = AMP_W'(amp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // 1. Reset, no note.
        idle(3);
        check("t1_in_reset", int'(envelope), 0);
        rst = 1'b1;
        idle(5);
        check("t1_after_release", int'(envelope), 0);

        // 2. A=8, D=4, amplitude=99 (P=198), note held 50 clks.
        tick_period = 10;
        set_voice(8, 4, 99);
        note_pressed = 1'b1;
        idle(1);
        set_voice(1, 1, 5);          // mid-note changes must be ignored
        run_ticks(5);                // note still high here: no retrigger
        note_pressed = 1'b0;
        run_ticks(2);
        check("t2_tick7", int'(envelope), 0);
        run_ticks(1);
        check("t2_tick8", int'(envelope), 1);
        run_ticks(1575);
        check("t2_tick1583", int'(envelope), 197);
        run_ticks(1);
        check("t2_peak_tick1584", int'(envelope), 198);
        run_ticks(4);
        check("t2_tick1588", int'(envelope), 197);
        run_ticks(787);
        check("t2_tick2375", int'(envelope), 1);
        run_ticks(1);
        check("t2_zero_tick2376", int'(envelope), 0);
        run_ticks(3);
        check("t2_idle_hold", int'(envelope), 0);

        // 3. A=128, D=0, amplitude=63 (P=126); ticks every 2 clks keep the
        // 16k-tick attack short in simulation.
        tick_period = 2;
        set_voice(128, 0, 63);
        note_pressed = 1'b1;
        idle(3);
        note_pressed = 1'b0;
        run_ticks(16127);
        check("t3_tick16127", int'(envelope), 125);
        run_ticks(1);
        check("t3_peak_tick16128", int'(envelope), 126);
        run_ticks(1);
        check("t3_instant_decay", int'(envelope), 0);

        // 4. A=0, D=2, amplitude=10 (P=20); trigger collides with a tick.
        tick_period = 10;
        set_voice(0, 2, 10);
        note_pressed = 1'b1;
        sample_tick  = 1'b1;
        idle(1);
        sample_tick  = 1'b0;
        note_pressed = 1'b0;
        check("t4_tick_discarded", int'(envelope), 0);
        run_ticks(1);
        check("t4_instant_peak", int'(envelope), 20);
        run_ticks(1);
        check("t4_hold_1", int'(envelope), 20);
        run_ticks(1);
        check("t4_first_decay", int'(envelope), 19);
        run_ticks(40);
        check("t4_done", int'(envelope), 0);

        // 5. Retrigger during DECAY at level 50.
        tick_period = 4;
        set_voice(1, 1, 99);
        pulse_note();
        run_ticks(198);
        check("t5_peak", int'(envelope), 198);
        run_ticks(148);
        check("t5_decay_at_50", int'(envelope), 50);
        set_voice(2, 1, 99);
        pulse_note();
        check("t5_no_drop", int'(envelope), 50);
        run_ticks(2);
        check("t5_resume_up", int'(envelope), 51);
        run_ticks(294);
        check("t5_repeak", int'(envelope), 198);
        set_voice(1, 1, 10);         // lower peak: ramps down from 198
        pulse_note();
        run_ticks(1);
        check("t5_low_peak_decay", int'(envelope), 197);
        run_ticks(197);
        check("t5_low_peak_zero", int'(envelope), 0);
        set_voice(1, 1, 0);          // P=0 from level 0 stays idle
        pulse_note();
        run_ticks(3);
        check("t5_zero_peak", int'(envelope), 0);

        // 6. Async reset mid-attack, held note, then a fresh edge.
        tick_period = 10;
        set_voice(8, 4, 99);
        note_pressed = 1'b1;
        idle(1);
        run_ticks(40);
        check("t6_mid_attack", int'(envelope), 5);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("t6_async_clear", int'(envelope), 0);
        idle(2);
        rst = 1'b1;
        run_ticks(20);
        check("t6_held_no_restart", int'(envelope), 0);
        note_pressed = 1'b0;
        idle(1);
        note_pressed = 1'b1;
        idle(1);
        run_ticks(8);
        check("t6_new_edge", int'(envelope), 1);
        note_pressed = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
